// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO between fetch and decode.
// Define IF_ID_QUEUE_BYPASS_EN for same-cycle pass-through when empty.
module if_id_queue #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    input  logic             in_decompress_failed,
    input  logic             in_cond_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [ILEN-1:0]  out_instr,
    output logic             out_decompress_failed,
    output logic             out_cond_branch,
    input  logic             flush,
    input  logic             run_finished_next,
    output logic             run_done,
    output logic [CNT_W-1:0] count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [XLEN-1:0]   pc_mem [DEPTH];
    logic [ILEN-1:0]   instr_mem [DEPTH];
    logic [DEPTH-1:0]  df_mem;
    logic [DEPTH-1:0]  cb_mem;

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              done_pending;
    logic              run_done_q;

    logic              empty;
    logic              push;
    logic              pop;
    logic              byp;

    always_comb begin
        empty    = (cnt == '0);
        in_ready = (cnt != FULL);
        pop      = !empty && !flush && out_ready;
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp       = empty && in_valid && !flush;
        out_valid = (!empty && !flush) || byp;
        if (byp) begin
            out_pc                = in_pc;
            out_instr             = in_instr;
            out_decompress_failed = in_decompress_failed;
            out_cond_branch       = in_cond_branch;
        end else begin
            out_pc                = pc_mem[rd_ptr];
            out_instr             = instr_mem[rd_ptr];
            out_decompress_failed = df_mem[rd_ptr];
            out_cond_branch       = cb_mem[rd_ptr];
        end
`else
        byp                   = 1'b0;
        out_valid             = !empty && !flush;
        out_pc                = pc_mem[rd_ptr];
        out_instr             = instr_mem[rd_ptr];
        out_decompress_failed = df_mem[rd_ptr];
        out_cond_branch       = cb_mem[rd_ptr];
`endif
        // a bypassed beat consumed by decode never touches storage
        push = in_valid && in_ready && !flush
            && !(byp && out_ready);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            df_mem[wr_ptr]    <= in_decompress_failed;
            cb_mem[wr_ptr]    <= in_cond_branch;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // done_pending survives flush; only reset clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_pending <= 1'b0;
            run_done_q   <= 1'b0;
        end else begin
            if (run_finished_next) done_pending <= 1'b1;
            run_done_q <= done_pending && empty;
        end
    end

    assign run_done = run_done_q;
    assign count    = cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised scoreboard bench for if_id_queue.
// Reference model is a plain queue of expected entries.
module tb_if_id_queue;

    localparam int DEPTH = 4;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        df;
        logic        cb;
    } ent_t;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_decompress_failed;
    logic        in_cond_branch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_decompress_failed;
    logic        out_cond_branch;
    logic        flush;
    logic        run_finished_next;
    logic        run_done;
    logic [2:0]  count;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   dp_m;
    bit   rd_m;

    if_id_queue dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_pc                (in_pc),
        .in_instr             (in_instr),
        .in_decompress_failed (in_decompress_failed),
        .in_cond_branch       (in_cond_branch),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_pc               (out_pc),
        .out_instr            (out_instr),
        .out_decompress_failed(out_decompress_failed),
        .out_cond_branch      (out_cond_branch),
        .flush                (flush),
        .run_finished_next    (run_finished_next),
        .run_done             (run_done),
        .count                (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented head against the model front
    always @(negedge clk) begin
        #2;
        if (rstn === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL head: unexpected entry pc %0h at %0t",
                         out_pc, $time);
            end else begin
                chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
                chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
                chk("out_df", 64'(out_decompress_failed), 64'(sb[0].df));
                chk("out_cb", 64'(out_cond_branch), 64'(sb[0].cb));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        in_valid             = 1'b0;
        in_pc                = '0;
        in_instr             = '0;
        in_decompress_failed = 1'b0;
        in_cond_branch       = 1'b0;
        out_ready            = 1'b0;
        flush                = 1'b0;
        run_finished_next    = 1'b0;
    endtask

    // One clock cycle of stimulus plus the model update for it
    task automatic cycle(input bit iv, input logic [31:0] pc,
                         input logic [31:0] ins, input bit df,
                         input bit cb, input bit ordy, input bit fl,
                         input bit rfn);
        int   pre;
        bit   exp_ov;
        ent_t e;
        @(negedge clk);
        in_valid             = iv;
        in_pc                = pc;
        in_instr             = ins;
        in_decompress_failed = df;
        in_cond_branch       = cb;
        out_ready            = ordy;
        flush                = fl;
        run_finished_next    = rfn;
        #1;
        pre    = sb.size();
        exp_ov = !fl && (pre != 0 || (BYP && iv));
        chk("count", 64'(count), 64'(pre));
        chk("in_ready", 64'(in_ready), 64'(pre != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("run_done", 64'(run_done), 64'(rd_m));
        if (fl) begin
            sb.delete();
        end else if (iv && pre < DEPTH) begin
            e.pc    = pc;
            e.instr = ins;
            e.df    = df;
            e.cb    = cb;
            sb.push_back(e);
        end
        rd_m = dp_m && (pre == 0);
        dp_m = dp_m | rfn;
    endtask

    task automatic push1(input logic [31:0] pc, input bit ordy);
        cycle(1'b1, pc, pc ^ 32'h1357_9bdf, pc[2], pc[3], ordy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #4 rstn = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_run_done", 64'(run_done), 64'd0);
        sb.delete();
        dp_m = 1'b0;
        rd_m = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        dp_m = 1'b0;
        rd_m = 1'b0;
        #1;
        chk("init_count", 64'(count), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd1);
        do_reset();

        // fill to DEPTH then drain in order
        for (int i = 0; i < DEPTH; i++) push1(32'h100 + 32'(4 * i), 1'b0);
        idle(1, 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        idle(DEPTH + 1, 1'b1);

        // steady streaming at occupancy 2 across pointer wrap
        push1(32'h400, 1'b0);
        push1(32'h404, 1'b0);
        for (int i = 0; i < 20; i++) push1(32'h408 + 32'(4 * i), 1'b1);
        idle(3, 1'b1);

        // full buffer offered a beat while popping: pop only
        for (int i = 0; i < DEPTH; i++) push1(32'h600 + 32'(4 * i), 1'b0);
        push1(32'h6f0, 1'b1);
        idle(1, 1'b0);
        chk("pop_only_count", 64'(count), 64'd3);

        // flush with count=3 and a beat offered
        cycle(1'b1, 32'h7f0, 32'h7f0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // bypass / one-cycle latency from empty
        push1(32'h200, 1'b1);
        idle(2, 1'b1);

        // drain detection
        push1(32'h300, 1'b0);
        push1(32'h304, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b1);
        chk("run_done_sticky", 64'(run_done), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("run_done_after_flush", 64'(run_done), 64'd1);

        // random traffic, with an asynchronous reset in the middle
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                      1'($urandom), 1'($urandom),
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 24) == 0,
                      $urandom_range(0, 60) == 0);
            end
            push1(32'hdead_0000, 1'b0);
        end

        idle(DEPTH + 2, 1'b1);
        chk("final_count", 64'(count), 64'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer between the fetch stage and decode, replacing the single IF/ID pipeline register. It holds up to DEPTH fetched instructions, each with its PC and per-instruction status flags. It decouples fetch and decode through valid/ready handshakes on both sides. It also supports a pipeline flush and end-of-program drain detection.

## Interface
- XLEN, 32, width of PC fields.
- ILEN, 32, width of the instruction word.
- DEPTH, 4, number of entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), width of the count output; derived, never overridden.
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  buffer accepts an entry this cycle.
- in_pc  in  XLEN  PC of the incoming instruction.
- in_instr  in  ILEN  decompressed instruction.
- in_decompress_failed  in  1  decompressor rejected this instruction.
- in_cond_branch  in  1  instruction is a conditional branch.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode consumes the head entry.
- out_pc, out_instr, out_decompress_failed, out_cond_branch  out  XLEN/ILEN/1/1  head entry fields.
- flush  in  1  synchronous discard of all entries (branch mispredict or if_id_flush).
- run_finished_next  in  1  fetch has issued its last instruction.
- run_done  out  1  last instruction issued and buffer drained.
- count  out  CNT_W  current occupancy.

## Operation
- Circular buffer with ADDR_W = log2(DEPTH) read and write pointers that wrap naturally. Occupancy is tracked in an explicit count register (0..DEPTH).
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). There is no enqueue-while-full, even when a pop happens in the same cycle.
- out_valid = (count != 0) && !flush. Head fields always show the entry at the read pointer. They are undefined-but-stable when count==0; the implementation drives the stale RAM contents, never X.
- If push and pop occur in the same cycle, count is unchanged and both pointers advance.
- Flush has priority over everything:
  - pointers and count go to 0 on the next edge;
  - the input beat offered that cycle is dropped;
  - no pop occurs.
- Drain tracking:
  - a sticky done_pending flag sets on run_finished_next;
  - flush does not clear it; only reset does;
  - run_done = done_pending && (count==0), registered: it asserts the cycle after both conditions hold.
- Entry storage is flops, not reset. Pointers, count, done_pending and run_done are reset.
- Reset values: count=0, out_valid=0, in_ready=1, run_done=0, pointers=0.
- Reset asserted mid-operation immediately empties the buffer, asynchronously. In-flight entries are lost.

## Timing
- Latency without bypass: an entry pushed at edge N is visible on out_valid after edge N, so it can be popped in cycle N+1.
- Throughput is one push and one pop per cycle at any occupancy 0 < count < DEPTH.
- in_ready and out_valid depend only on registered state and flush. There is no combinational path from out_ready to in_ready.
- Flush asserted in cycle N: out_valid is low in cycle N. After edge N, count=0 and in_ready=1.
- run_done is registered with one cycle of latency after the last pop, or after run_finished_next if the buffer is already empty.

## Configuration
- IF_ID_QUEUE_BYPASS_EN, when defined:
  - when count==0, in_valid && !flush forces out_valid=1 with the out_* fields driven from the in_* fields in the same cycle;
  - if out_ready is also high, the beat passes through without being written, and count stays 0;
  - otherwise it is written normally.
  - This adds a combinational in→out path.
- Undefined: no bypass, so minimum latency is one cycle and out_* come only from storage.

## Test plan
- Reset, then push 4 entries (pc 0x100..0x10C) with out_ready=0 → count=4, in_ready=0. Then pop all → pcs appear in order 0x100..0x10C, count returns to 0.
- Continuous push and pop with DEPTH=4 over 20 beats → count stays constant, pointers wrap, no reordering and no drops.
- Full buffer, in_valid=1 and out_ready=1 in the same cycle → pop only, input not accepted, count 4→3.
- count=3 with flush=1 and in_valid=1 → out_valid=0 that cycle, next cycle count=0, and the flushed and offered entries never appear.
- Pulse run_finished_next with count=2, then pop 2 → run_done rises exactly one cycle after count reaches 0 and stays high until reset.
- With IF_ID_QUEUE_BYPASS_EN: empty buffer, in_valid=1, in_pc=0x200, out_ready=1 → out_valid=1 and out_pc=0x200 in the same cycle, count stays 0. Without the macro: out_valid rises one cycle later.
